nes_joypad_dev: RTL

- Device-side model of a standard NES controller (4021-style 8-bit parallel-in/serial-out shifter).
- Answers the console's controller port: strobe latches the buttons, each read pulse advances one bit, and the serial data line is driven back.
- Sits on the far end of the console's ctrl_strobe / ctrl_out / ctrl_data wires. Used in benches and loopback builds in place of a physical pad; button state comes from FPGA buttons/switches or a test driver.
- The strobe and read-clock inputs are asynchronous to clk and are synchronised internally.

---
 rtl/nes_joypad_dev.sv | 106 ++++++++++
 1 files changed

// File: rtl/nes_joypad_dev.sv
// NES controller (4021-style) device model: strobe latches buttons, rd_n rising edge shifts.
// Optional turbo on A/B is built only when NES_JOYPAD_TURBO_EN is defined.
module nes_joypad_dev #(
  parameter int SYNC_STAGES     = 2,
  parameter int DATA_ACTIVE_LOW = 1,
  parameter int TURBO_DIV       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] buttons,
  input  logic [1:0] turbo,
  input  logic       strobe_i,
  input  logic       rd_n_i,
  output logic       data_o,
  output logic [3:0] bit_cnt_o
);

  logic [SYNC_STAGES-1:0] r_strb_sync;
  logic [SYNC_STAGES-1:0] r_rd_sync;
  logic                   r_strb_d;
  logic                   r_rd_d;
  logic [7:0]             r_sr;
  logic [3:0]             r_bit_cnt;

  logic       w_strb;
  logic       w_rd;
  logic       w_strb_fall;
  logic       w_rd_rise;
  logic [7:0] w_eff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_strb_sync <= '0;
      r_rd_sync   <= '1;
      r_strb_d    <= 1'b0;
      r_rd_d      <= 1'b1;
    end else begin
      r_strb_sync <= {r_strb_sync[SYNC_STAGES-2:0], strobe_i};
      r_rd_sync   <= {r_rd_sync[SYNC_STAGES-2:0], rd_n_i};
      r_strb_d    <= w_strb;
      r_rd_d      <= w_rd;
    end
  end

  assign w_strb      = r_strb_sync[SYNC_STAGES-1];
  assign w_rd        = r_rd_sync[SYNC_STAGES-1];
  assign w_strb_fall = r_strb_d & ~w_strb;
  assign w_rd_rise   = w_rd & ~r_rd_d;

`ifdef NES_JOYPAD_TURBO_EN
  logic [7:0] r_turbo_cnt;
  logic       r_phase;

  // Counts polls (strobe falling edges); phase flips every TURBO_DIV polls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_turbo_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (w_strb_fall) begin
      if (r_turbo_cnt == 8'(TURBO_DIV - 1)) begin
        r_turbo_cnt <= '0;
        r_phase     <= ~r_phase;
      end else begin
        r_turbo_cnt <= r_turbo_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    w_eff    = buttons;
    w_eff[0] = buttons[0] & (~turbo[0] | r_phase);
    w_eff[1] = buttons[1] & (~turbo[1] | r_phase);
  end
`else
  logic w_unused_turbo;
  assign w_unused_turbo = ^{turbo, w_strb_fall};
  assign w_eff          = buttons;
`endif

  // Latch has priority over a coincident read edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr      <= '0;
      r_bit_cnt <= '0;
    end else if (w_strb) begin
      r_sr      <= w_eff;
      r_bit_cnt <= '0;
    end else if (w_rd_rise) begin
      r_sr <= {1'b1, r_sr[7:1]};
      if (r_bit_cnt != 4'd8) begin
        r_bit_cnt <= r_bit_cnt + 4'd1;
      end
    end
  end

  generate
    if (DATA_ACTIVE_LOW != 0) begin : g_wire
      assign data_o = ~r_sr[0];
    end else begin : g_logical
      assign data_o = r_sr[0];
    end
  endgenerate

  assign bit_cnt_o = r_bit_cnt;

endmodule
